// File: rtl/calc_alu_seq.sv
// calc_alu_seq: sequential sign-magnitude add/subtract/multiply unit with saturation.
module calc_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             error
);
    localparam int M  = WIDTH - 1;
    localparam int PW = 2 * M;
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, ADDSUB, MUL, FIN} state_t;
    state_t state, state_nx;
    logic sa, sb;
    logic [M-1:0] ma, mb;
    logic [PW-1:0] acc, partial, raw_mag;
    logic [CW-1:0] cnt;
    logic [M:0] xa, xb, sum_mag;
    logic is_add, is_sub, is_mul, mul_last, a_ge_b, sum_sign, raw_sign, ovf, res_sign;
    logic [M-1:0] sat_mag;
    assign is_add   = op == 3'b010;
    assign is_sub   = op == 3'b011;
    assign is_mul   = op == 3'b100;
    assign mul_last = cnt == CW'(M - 1);
    assign busy     = state != IDLE;
    assign done     = state == FIN;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (is_add || is_sub) ? ADDSUB : is_mul ? MUL : FIN;
            ADDSUB:  state_nx = FIN;
            MUL:     if (mul_last) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end
    // Unequal signs subtract the smaller magnitude and inherit the larger one's sign.
    always_comb begin
        xa       = {1'b0, ma};
        xb       = {1'b0, mb};
        a_ge_b   = xa >= xb;
        sum_mag  = (sa == sb) ? xa + xb : a_ge_b ? xa - xb : xb - xa;
        sum_sign = (sa == sb) ? sa : a_ge_b ? sa : sb;
        partial  = mb[cnt] ? acc + ({{M{1'b0}}, ma} << cnt) : acc;
        raw_mag  = (state == MUL) ? partial : PW'(sum_mag);
        raw_sign = (state == MUL) ? sa ^ sb : sum_sign;
        ovf      = |raw_mag[PW-1:M];
        sat_mag  = ovf ? {M{1'b1}} : raw_mag[M-1:0];
        res_sign = raw_sign & (sat_mag != '0);
    end
    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= IDLE;
            sa       <= 1'b0;
            sb       <= 1'b0;
            ma       <= '0;
            mb       <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
            error    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    sa       <= operand_a[WIDTH-1];
                    ma       <= operand_a[M-1:0];
                    sb       <= operand_b[WIDTH-1] ^ is_sub;
                    mb       <= operand_b[M-1:0];
                    acc      <= '0;
                    cnt      <= '0;
                    result   <= '0;
                    overflow <= 1'b0;
                    error    <= !(is_add || is_sub || is_mul);
                end
                ADDSUB: begin
                    result   <= {res_sign, sat_mag};
                    overflow <= ovf;
                end
                MUL: begin
                    acc <= partial;
                    cnt <= cnt + 1'b1;
                    if (mul_last) begin
                        result   <= {res_sign, sat_mag};
                        overflow <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_alu_seq.sv
// tb_calc_alu_seq: vector table, randomized model comparison and multi-cycle corner sequences.
module tb_calc_alu_seq;
    logic clk = 1'b0, RST = 1'b1, start = 1'b0;
    logic [2:0] op = '0;
    logic [15:0] operand_a = '0, operand_b = '0;
    logic busy, done, overflow, error;
    logic [15:0] result;
    int errors = 0, checks = 0;

    calc_alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .RST(RST), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result(result),
        .overflow(overflow), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a, b, r;
        logic        ov, er;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: signed integer arithmetic, then saturate and normalise zero.
    function automatic void model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic ov, output logic er);
        int va, vb, v, mag;
        r = 0; ov = 0; er = 0;
        if (o != 3'd2 && o != 3'd3 && o != 3'd4) begin
            er = 1;
            return;
        end
        va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
        vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
        if (o == 3'd3) vb = -vb;
        v   = (o == 3'd4) ? va * vb : va + vb;
        mag = v < 0 ? -v : v;
        ov  = mag > 32767;
        if (ov) mag = 32767;
        r = {v < 0 && mag != 0, mag[14:0]};
    endfunction

    task automatic do_check(input string name, input logic [2:0] o, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] er_r, input logic e_ov,
                            input logic e_er);
        int lat, busy_lo, e_lat;
        e_lat = (o == 3'd2 || o == 3'd3) ? 2 : (o == 3'd4) ? 16 : 1;
        @(negedge clk);
        RST = 0; op = o; operand_a = a; operand_b = b; start = 1;
        @(posedge clk); #1;
        start = 0; op = 3'($urandom); operand_a = 16'($urandom); operand_b = 16'($urandom);
        lat = 1; busy_lo = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_lo++;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_lo++;
        chk({name, " latency"}, lat, e_lat);
        chk({name, " busy_low"}, busy_lo, 0);
        chk({name, " result"}, result, er_r);
        chk({name, " overflow"}, overflow, e_ov);
        chk({name, " error"}, error, e_er);
        @(posedge clk); #1;
        chk({name, " done_pulse"}, done, 0);
        chk({name, " busy_after"}, busy, 0);
        chk({name, " result_hold"}, {overflow, error, result}, {e_ov, e_er, er_r});
    endtask

    initial begin
        vec_t vecs[14];
        logic [15:0] mr;
        logic mov, mer;
        int dn;
        vecs = '{
            '{3'd4, 16'h0004, 16'h0003, 16'h000C, 1'b0, 1'b0},
            '{3'd4, 16'h9249, 16'h0007, 16'hFFFF, 1'b0, 1'b0},
            '{3'd4, 16'h00B5, 16'h00B5, 16'h7FF9, 1'b0, 1'b0},
            '{3'd2, 16'h800A, 16'h000A, 16'h0000, 1'b0, 1'b0},
            '{3'd3, 16'h0003, 16'h0005, 16'h8002, 1'b0, 1'b0},
            '{3'd2, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0},
            '{3'd4, 16'h8100, 16'h0100, 16'hFFFF, 1'b1, 1'b0},
            '{3'd0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1},
            '{3'd7, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1},
            '{3'd2, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0},
            '{3'd3, 16'h8005, 16'h0005, 16'h800A, 1'b0, 1'b0},
            '{3'd4, 16'h8003, 16'h8003, 16'h0009, 1'b0, 1'b0},
            '{3'd4, 16'h8000, 16'h0005, 16'h0000, 1'b0, 1'b0},
            '{3'd2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0}
        };
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {busy, done, overflow, error, result}, '0);
        foreach (vecs[i])
            do_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].r, vecs[i].ov, vecs[i].er);

        for (int i = 0; i < 40; i++) begin
            int r;
            logic [2:0] o;
            logic [15:0] a, b;
            r = $urandom_range(0, 9);
            o = r < 3 ? 3'd2 : r < 6 ? 3'd3 : r < 9 ? 3'd4 : 3'($urandom_range(5, 7));
            a = {1'($urandom), 15'($urandom_range(0, (i % 2) ? 255 : 32767))};
            b = {1'($urandom), 15'($urandom_range(0, (i % 3) ? 255 : 32767))};
            model(o, a, b, mr, mov, mer);
            do_check($sformatf("rnd%0d", i), o, a, b, mr, mov, mer);
        end

        // Start pulsed mid-multiply must be ignored.
        @(negedge clk);
        op = 3'd4; operand_a = 16'h0004; operand_b = 16'h0003; start = 1;
        @(posedge clk); #1;
        start = 0; dn = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                dn++;
                chk("ignore done_cycle", k, 16);
            end
            if (k == 4) begin
                start = 1; op = 3'd2; operand_a = 16'h0001; operand_b = 16'h0001;
            end
            if (k == 6) start = 0;
            @(posedge clk); #1;
        end
        chk("ignore done_count", dn, 1);
        chk("ignore result", result, 16'h000C);

        // Start held high: not accepted on the edge leaving FIN, accepted on the next.
        @(negedge clk);
        op = 3'd2; operand_a = 16'h0001; operand_b = 16'h0002; start = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b done", done, 1);
        @(posedge clk); #1;
        chk("b2b idle_gap", busy, 0);
        @(posedge clk); #1;
        chk("b2b reaccept", busy, 1);
        start = 0;
        @(posedge clk); #1;
        chk("b2b second", {done, result}, {1'b1, 16'h0003});
        @(posedge clk); #1;

        // Reset in the middle of a multiply aborts it without a done pulse.
        @(negedge clk);
        op = 3'd4; operand_a = 16'h0123; operand_b = 16'h0045; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(posedge clk);
        #1;
        RST = 1;
        @(posedge clk); #1;
        chk("abort outputs", {busy, done, overflow, error, result}, '0);
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        chk("abort no_done", dn, 0);
        do_check("post_reset add", 3'd2, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
